uart_txer: RTL
==============

// Module: uart_txer
// PURPOSE
//   UART serial transmitter, 8N1, LSB first; the transmit counterpart of the UART_RXer receiver.
//   The user pushes bytes through a small FIFO; the block serialises them onto TX.
//   Consecutive frames go out back-to-back.
//   Default timing: 24 MHz system clock, 4800 baud.
// PARAMETERS
//   CLK_FREQ    24_000_000  system clock frequency, Hz
//   BAUD        4800        line rate, bit/s; BIT_CYCLES = CLK_FREQ/BAUD (default 5000)
//   FIFO_DEPTH  4           byte FIFO entries; power of 2, >= 2
// PORTS
//   clk         in   1  system clock, rising edge
//   rstn        in   1  asynchronous active-low reset
//   data_in     in   8  byte to transmit; sampled when en_data_in=1
//   en_data_in  in   1  one-cycle write strobe; pushes data_in into FIFO if full=0
//   full        out  1  FIFO holds FIFO_DEPTH bytes; writes are dropped
//   busy        out  1  1 while FIFO is non-empty or a frame is in progress
//   TX          out  1  serial line, registered, idles high
// BEHAVIOUR
//   Reset (async, any state, including mid-frame):
//     TX=1, busy=0, full=0, FIFO empty, FSM=IDLE, bit and baud counters=0.
//     A partial frame is abandoned; the line returns high immediately.
//   FIFO:
//     Write when en_data_in=1 and full=0 (full sampled before the edge).
//     A write while full=1 is dropped silently, even if a pop occurs on the same edge.
//     Simultaneous write and pop when not full: count unchanged, both take effect.
//     Read and write pointers wrap modulo FIFO_DEPTH.
//     Count width is clog2(FIFO_DEPTH)+1; full=(count==FIFO_DEPTH).
//   FSM states:
//     IDLE  : TX=1. If FIFO non-empty: pop head into shift reg, TX<=0, -> START.
//     START : hold TX=0 for BIT_CYCLES clocks; then TX<=shift[0], bit_idx=0, -> DATA.
//     DATA  : each bit held BIT_CYCLES clocks. At bit end: shift right.
//             If bit_idx==7, TX<=1 and -> STOP; else bit_idx++ and TX<=next bit.
//     STOP  : hold TX=1 for BIT_CYCLES clocks. At end:
//             if FIFO non-empty, pop, TX<=0, -> START (no idle gap); else -> IDLE.
//   Timing:
//     Baud counter runs 0..BIT_CYCLES-1, resets at each bit boundary.
//     Every bit, including start and stop, lasts exactly BIT_CYCLES clocks.
//     Frame length is 10*BIT_CYCLES clocks.
//     Latency: a strobe on edge k into an empty FIFO while IDLE drives TX low from edge k+1.
//   busy = (FSM!=IDLE) | (count!=0). Registered or combinational is allowed;
//     it must be 1 no later than the cycle TX first goes low.
//   data_in changing after its strobe edge has no effect on the queued byte.
// TESTING (bench samples TX at mid-bit; use BIT_CYCLES=16 for speed, plus one default run)
//   1 Reset: rstn=0 -> TX=1, busy=0, full=0. Release, no writes for 100 clk -> TX stays 1.
//   2 Single byte: write 8'hA5 -> line shows 0,1,0,1,0,0,1,0,1,1 (start, b0..b7, stop).
//     Each level lasts 16 clk; busy drops after the stop bit.
//   3 Back-to-back: write 8'h00 then 8'hFF on consecutive cycles
//     -> two frames, 320 clk total, no idle cycles between them.
//   4 Overflow: 6 writes (8'h01..8'h06) in 6 cycles while idle
//     -> full asserts, 8'h06 is dropped, line carries 01,02,03,04,05 in order.
//   5 Reset mid-frame: assert rstn during bit 3 of 8'h55
//     -> TX=1 immediately, FIFO empty, next write sends a clean frame.
//   6 Default params: 8'h3C at 24 MHz -> each bit 5000 clk, frame 50000 clk.

Source files
------------

// File: rtl/uart_txer.sv
// -----------------------------------------------------------------------------
// uart_txer
//   UART serial transmitter, 8 data bits, no parity, 1 stop bit, LSB first.
//   Bytes are queued in a small FIFO and serialised onto TX. When another byte
//   is waiting at the end of a stop bit, the next start bit follows
//   immediately, with no idle time between frames.
//
// Ports
//   clk         system clock, rising edge
//   rstn        asynchronous active-low reset
//   data_in     byte to queue, captured on the edge where en_data_in=1
//   en_data_in  one-cycle write strobe; ignored while full=1
//   full        FIFO holds FIFO_DEPTH bytes
//   busy        a frame is in progress or bytes are still queued
//   TX          registered serial line, idles high
// -----------------------------------------------------------------------------
module uart_txer #(
    parameter int CLK_FREQ   = 24_000_000,
    parameter int BAUD       = 4800,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] data_in,
    input  logic       en_data_in,
    output logic       full,
    output logic       busy,
    output logic       TX
);

    localparam int BIT_CYCLES = CLK_FREQ / BAUD;
    localparam int CW         = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int AW         = $clog2(FIFO_DEPTH);
    localparam int CNTW       = AW + 1;

    localparam logic [CW-1:0]   LAST_CYC = CW'(BIT_CYCLES - 1);
    localparam logic [CNTW-1:0] DEPTH_C  = CNTW'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [7:0]      mem [0:FIFO_DEPTH-1];
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [CNTW-1:0] count_reg;

    logic [1:0]      state_reg;
    logic [CW-1:0]   baud_cnt_reg;
    logic [2:0]      bit_idx_reg;
    logic [7:0]      shift_reg;
    logic            tx_reg;

    logic            bit_end;
    logic            fifo_nonempty;
    logic            push;
    logic            pop;
    logic [7:0]      head;

    assign bit_end       = (baud_cnt_reg == LAST_CYC);
    assign fifo_nonempty = (count_reg != '0);
    assign full          = (count_reg == DEPTH_C);
    // full is the pre-edge value, so a write while full is dropped even if
    // the FSM pops on the same edge.
    assign push          = en_data_in & ~full;
    // The FSM takes the head byte when idle, or at the end of a stop bit to
    // chain the next frame without a gap.
    assign pop           = fifo_nonempty &
                           ((state_reg == S_IDLE) | ((state_reg == S_STOP) & bit_end));
    assign busy          = (state_reg != S_IDLE) | fifo_nonempty;
    assign TX            = tx_reg;
    assign head          = mem[rd_ptr_reg];

    // FIFO storage: contents need no reset, only the pointers and count do.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= data_in;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNTW'(1);
                2'b01:   count_reg <= count_reg - CNTW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Frame sequencer. TX is updated on the same edge that changes state, so
    // every bit, start and stop included, is held exactly BIT_CYCLES clocks.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg    <= S_IDLE;
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            shift_reg    <= '0;
            tx_reg       <= 1'b1;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    tx_reg       <= 1'b1;
                    baud_cnt_reg <= '0;
                    if (fifo_nonempty) begin
                        shift_reg <= head;
                        tx_reg    <= 1'b0;
                        state_reg <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        baud_cnt_reg <= '0;
                        bit_idx_reg  <= '0;
                        tx_reg       <= shift_reg[0];
                        state_reg    <= S_DATA;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + CW'(1);
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        baud_cnt_reg <= '0;
                        shift_reg    <= {1'b0, shift_reg[7:1]};
                        if (bit_idx_reg == 3'd7) begin
                            tx_reg    <= 1'b1;
                            state_reg <= S_STOP;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                            // shift_reg[1] becomes bit 0 after this edge
                            tx_reg      <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + CW'(1);
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        baud_cnt_reg <= '0;
                        if (fifo_nonempty) begin
                            shift_reg <= head;
                            tx_reg    <= 1'b0;
                            state_reg <= S_START;
                        end else begin
                            state_reg <= S_IDLE;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + CW'(1);
                    end
                end
                default: begin
                    tx_reg    <= 1'b1;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule
